// File: rtl/spi_tx_fifo_if.sv
// Handshake bundle between host write logic, the SPI core and the TX FIFO.
// Ports: write port (wr_*), core request port (fifo_*), status (used, pulses).
interface spi_tx_fifo_if #(
    parameter int data_width_g = 8,
    parameter int cnt_width_g  = 5
);
    logic                    wr_en;
    logic [data_width_g-1:0] wr_din;
    logic                    wr_full;
    logic                    wr_overflow;
    logic                    fifo_req_data;
    logic [data_width_g-1:0] fifo_din;
    logic                    fifo_din_valid;
    logic                    fifo_empty;
    logic                    rd_underflow;
    logic [cnt_width_g-1:0]  used;

    // FIFO side
    modport slave (
        input  wr_en,
        input  wr_din,
        input  fifo_req_data,
        output wr_full,
        output wr_overflow,
        output fifo_din,
        output fifo_din_valid,
        output fifo_empty,
        output rd_underflow,
        output used
    );

    // Host / core side
    modport master (
        output wr_en,
        output wr_din,
        output fifo_req_data,
        input  wr_full,
        input  wr_overflow,
        input  fifo_din,
        input  fifo_din_valid,
        input  fifo_empty,
        input  rd_underflow,
        input  used
    );
endinterface

// File: rtl/spi_tx_fifo.sv
// Transmit buffer answering the SPI core's fifo_req_data pulses, one word each.
// Ports: clk, rst (sync, active high), bus (spi_tx_fifo_if.slave).
module spi_tx_fifo #(
    parameter int data_width_g = 8,
    parameter int depth_g      = 16,
    parameter int cnt_width_g  = $clog2(depth_g) + 1
) (
    input  logic          clk,
    input  logic          rst,
    spi_tx_fifo_if.slave  bus
);
    localparam int ptr_width_c = $clog2(depth_g);

    logic [data_width_g-1:0] mem [depth_g];

    logic [ptr_width_c-1:0]  wr_ptr;
    logic [ptr_width_c-1:0]  rd_ptr;
    logic [cnt_width_g-1:0]  used_q;
    logic [cnt_width_g-1:0]  used_nxt;
    logic                    empty_q;
    logic                    full_q;
    logic                    valid_q;
    logic [data_width_g-1:0] dout_q;
    logic                    ovf_q;
    logic                    und_q;

    logic push_acc;
    logic pop_acc;

    // Acceptance uses registered flags only, so a pop never frees a slot
    // for a same-cycle push and a push never satisfies a same-cycle request.
    assign push_acc = bus.wr_en & ~full_q;
    assign pop_acc  = bus.fifo_req_data & ~empty_q;

    always_comb begin
        used_nxt = used_q;
        unique case ({push_acc, pop_acc})
            2'b10:   used_nxt = used_q + cnt_width_g'(1);
            2'b01:   used_nxt = used_q - cnt_width_g'(1);
            default: used_nxt = used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            used_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ptr_width_c'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ptr_width_c'(1);
                dout_q <= mem[rd_ptr];
            end
            valid_q <= pop_acc;
            ovf_q   <= bus.wr_en & full_q;
            und_q   <= bus.fifo_req_data & empty_q;
            used_q  <= used_nxt;
            empty_q <= (used_nxt == '0);
            full_q  <= (used_nxt == cnt_width_g'(depth_g));
        end
    end

    // Storage has no reset; contents are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            mem[wr_ptr] <= bus.wr_din;
        end
    end

    assign bus.wr_full        = full_q;
    assign bus.wr_overflow    = ovf_q;
    assign bus.fifo_din       = dout_q;
    assign bus.fifo_din_valid = valid_q;
    assign bus.fifo_empty     = empty_q;
    assign bus.rd_underflow   = und_q;
    assign bus.used           = used_q;
endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo: queue model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_spi_tx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_tx_fifo_if #(.data_width_g(8), .cnt_width_g(5)) bus ();

    spi_tx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words and the registered outputs.
    logic [7:0] q[$];
    logic       m_valid;
    logic [7:0] m_din;
    logic       m_ovf;
    logic       m_und;

    initial begin
        m_valid = 0;
        m_din   = 0;
        m_ovf   = 0;
        m_und   = 0;
    end

    always @(posedge clk) begin
        int n;
        bit was_full, was_empty;
        n = q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (rst) begin
            q.delete();
            m_valid = 0;
            m_din   = 0;
            m_ovf   = 0;
            m_und   = 0;
        end else begin
            m_ovf   = bus.wr_en && was_full;
            m_und   = bus.fifo_req_data && was_empty;
            m_valid = bus.fifo_req_data && !was_empty;
            if (m_valid) m_din = q.pop_front();
            if (bus.wr_en && !was_full) q.push_back(bus.wr_din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", bus.fifo_din_valid, m_valid);
            chk("din", bus.fifo_din, m_din);
            chk("used", bus.used, q.size());
            chk("empty", bus.fifo_empty, q.size() == 0);
            chk("full", bus.wr_full, q.size() == DEPTH);
            chk("overflow", bus.wr_overflow, m_ovf);
            chk("underflow", bus.rd_underflow, m_und);
        end
    end

    task automatic tick(input logic we, input logic [7:0] d,
                        input logic req, input logic r);
        bus.wr_en         = we;
        bus.wr_din        = d;
        bus.fifo_req_data = req;
        rst               = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en         = 0;
        bus.wr_din        = 0;
        bus.fifo_req_data = 0;
        rst               = 1;

        tick(0, 8'h00, 0, 1);
        tick(0, 8'h00, 0, 1);
        chk_en = 1;
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_used", bus.used, 0);
        chk("rst_din", bus.fifo_din, 0);

        // Scenario 1: three pushes, spaced requests
        tick(1, 8'hA1, 0, 0);
        tick(1, 8'hB2, 0, 0);
        tick(1, 8'hC3, 0, 0);
        chk("s1_used3", bus.used, 3);
        tick(0, 8'h00, 1, 0);
        chk("s1_v0", bus.fifo_din_valid, 1);
        chk("s1_d0", bus.fifo_din, 8'hA1);
        chk("s1_u2", bus.used, 2);
        tick(0, 8'h00, 0, 0);
        chk("s1_hold", bus.fifo_din, 8'hA1);
        chk("s1_nv", bus.fifo_din_valid, 0);
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 1, 0);
        chk("s1_d1", bus.fifo_din, 8'hB2);
        chk("s1_u1", bus.used, 1);
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 1, 0);
        chk("s1_d2", bus.fifo_din, 8'hC3);
        chk("s1_u0", bus.used, 0);
        chk("s1_empty", bus.fifo_empty, 1);
        tick(0, 8'h00, 0, 0);

        // Scenario 2: fill, overflow, full-throughput drain
        for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
        chk("s2_full", bus.wr_full, 1);
        chk("s2_used16", bus.used, 16);
        tick(1, 8'hFF, 0, 0);
        chk("s2_ovf", bus.wr_overflow, 1);
        chk("s2_used_keep", bus.used, 16);
        tick(0, 8'h00, 0, 0);
        chk("s2_ovf_once", bus.wr_overflow, 0);
        for (int i = 0; i < 16; i++) begin
            tick(0, 8'h00, 1, 0);
            chk("s2_dv", bus.fifo_din_valid, 1);
            chk("s2_dd", bus.fifo_din, 8'(i));
        end
        tick(0, 8'h00, 0, 0);
        chk("s2_empty", bus.fifo_empty, 1);

        // Scenario 3: request + push into empty FIFO
        tick(1, 8'h5A, 1, 0);
        chk("s3_und", bus.rd_underflow, 1);
        chk("s3_nv", bus.fifo_din_valid, 0);
        chk("s3_used1", bus.used, 1);
        chk("s3_nempty", bus.fifo_empty, 0);
        tick(0, 8'h00, 1, 0);
        chk("s3_v", bus.fifo_din_valid, 1);
        chk("s3_d", bus.fifo_din, 8'h5A);
        chk("s3_und0", bus.rd_underflow, 0);

        // Scenario 4: steady state at used=8, pointers wrap
        for (int i = 0; i < 8; i++) tick(1, 8'h40 + 8'(i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1, 8'h80 + 8'(i), 1, 0);
            chk("s4_used", bus.used, 8);
            chk("s4_v", bus.fifo_din_valid, 1);
            chk("s4_d", bus.fifo_din,
                (i < 8) ? 8'h40 + 8'(i) : 8'h80 + 8'(i - 8));
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 8'h00, 1, 0);
            chk("s4_tail", bus.fifo_din, 8'h80 + 8'(32 + i));
        end
        chk("s4_empty", bus.fifo_empty, 1);

        // Scenario 5: reset with words stored and a pending request
        for (int i = 0; i < 5; i++) tick(1, 8'h60 + 8'(i), 0, 0);
        tick(0, 8'h00, 1, 1);
        chk("s5_nv", bus.fifo_din_valid, 0);
        chk("s5_empty", bus.fifo_empty, 1);
        chk("s5_used", bus.used, 0);
        tick(0, 8'h00, 0, 0);
        chk("s5_nv2", bus.fifo_din_valid, 0);
        tick(1, 8'h33, 0, 0);
        tick(0, 8'h00, 1, 0);
        chk("s5_v", bus.fifo_din_valid, 1);
        chk("s5_d", bus.fifo_din, 8'h33);

        // Scenario 6: full with simultaneous push and request
        for (int i = 0; i < 16; i++) tick(1, 8'h10 + 8'(i), 0, 0);
        tick(1, 8'hEE, 1, 0);
        chk("s6_d", bus.fifo_din, 8'h10);
        chk("s6_ovf", bus.wr_overflow, 1);
        chk("s6_used", bus.used, 15);
        for (int i = 1; i < 16; i++) begin
            tick(0, 8'h00, 1, 0);
            chk("s6_drain", bus.fifo_din, 8'h10 + 8'(i));
        end
        tick(0, 8'h00, 1, 0);
        chk("s6_no_ee", bus.fifo_din_valid, 0);
        chk("s6_und", bus.rd_underflow, 1);
        tick(0, 8'h00, 0, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
